// File: rtl/hram_cmd_ctrl.sv
// Serial command controller: assembles 5-byte UART frames, drives hyper_xface
// requests and returns a 4-byte response, MSB first.
module hram_cmd_ctrl #(
   parameter logic [31:0] CONST_VAL     = 32'd259,
   parameter int unsigned FRAME_TIMEOUT = 120000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        rx_rcv,
   input  logic [7:0]  rx_data,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic [31:0] hr_addr,
   output logic [31:0] hr_wr_d,
   output logic        hr_wr_req,
   output logic        hr_rd_req,
   input  logic        hr_busy,
   input  logic        hr_rd_rdy,
   input  logic [31:0] hr_rd_d,
   output logic [7:0]  drop_cnt
);

   localparam int unsigned TW      = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
   localparam bit          TO_EN   = (FRAME_TIMEOUT != 0);
   localparam int unsigned TO_LASTI = (FRAME_TIMEOUT == 0) ? 0 : FRAME_TIMEOUT - 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TO_LASTI);

   localparam logic [7:0] CMD_ADDR     = 8'd1;
   localparam logic [7:0] CMD_LOAD     = 8'd2;
   localparam logic [7:0] CMD_WRITE    = 8'd3;
   localparam logic [7:0] CMD_READ     = 8'd4;
   localparam logic [7:0] CMD_READ_REQ = 8'd5;
   localparam logic [7:0] CMD_COUNT    = 8'd6;
   localparam logic [7:0] CMD_CONST    = 8'd7;

   typedef enum logic [2:0] {
      S_RX, S_EXEC, S_WAIT_BUSY, S_LOAD_RESP, S_TX_BYTE, S_TX_WAIT
   } state_t;

   state_t        state;
   logic [39:0]   frame;
   logic [2:0]    byte_cnt;
   logic [TW-1:0] timer;
   logic [31:0]   count;
   logic [31:0]   rd_latch;
   logic [31:0]   resp_reg;
   logic [2:0]    tx_left;
   logic          tx_ready_q;

   logic [7:0]    cmd;
   logic [31:0]   d;
   logic [31:0]   resp_c;
   logic          timeout_c;
   logic          drop_inc_c;

   assign cmd = frame[39:32];
   assign d   = frame[31:0];

   // Response word for the command held in the frame
   always_comb begin
      resp_c = {24'hEEEEEE, cmd};
      case (cmd)
         CMD_ADDR, CMD_LOAD: resp_c = d;
         CMD_WRITE:          resp_c = 32'd3;
         CMD_READ:           resp_c = rd_latch;
         CMD_READ_REQ:       resp_c = 32'd5;
         CMD_COUNT:          resp_c = count;
         CMD_CONST:          resp_c = CONST_VAL;
         default:            ;
      endcase
   end

   // Partial-frame timeout and dropped-byte events
   always_comb begin
      timeout_c  = TO_EN && (state == S_RX) && !rx_rcv && (byte_cnt != 3'd0) && (timer == TO_LAST);
      drop_inc_c = (rx_rcv && (state != S_RX)) || timeout_c;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_RX;
         frame      <= 40'd0;
         byte_cnt   <= 3'd0;
         timer      <= '0;
         count      <= 32'd0;
         rd_latch   <= 32'd0;
         resp_reg   <= 32'd0;
         tx_left    <= 3'd0;
         tx_ready_q <= 1'b0;
         tx_start   <= 1'b0;
         tx_data    <= 8'd0;
         hr_addr    <= 32'd0;
         hr_wr_d    <= 32'd0;
         hr_wr_req  <= 1'b0;
         hr_rd_req  <= 1'b0;
         drop_cnt   <= 8'd0;
      end else begin
         hr_wr_req  <= 1'b0;
         hr_rd_req  <= 1'b0;
         tx_start   <= 1'b0;
         tx_ready_q <= tx_ready;

         if (hr_rd_rdy) rd_latch <= hr_rd_d;
         if (drop_inc_c && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;

         case (state)
            S_RX: begin
               if (rx_rcv) begin
                  frame <= {frame[31:0], rx_data};
                  timer <= '0;
                  if (byte_cnt == 3'd4) begin
                     byte_cnt <= 3'd0;
                     state    <= S_EXEC;
                  end else begin
                     byte_cnt <= byte_cnt + 3'd1;
                  end
               end else if (timeout_c) begin
                  byte_cnt <= 3'd0;
                  timer    <= '0;
               end else if (byte_cnt != 3'd0) begin
                  timer <= timer + TW'(1);
               end
            end
            S_EXEC: begin
               state <= S_LOAD_RESP;
               case (cmd)
                  CMD_ADDR: hr_addr <= d;
                  CMD_LOAD: hr_wr_d <= d;
                  CMD_WRITE: begin
                     if (hr_busy) state <= S_WAIT_BUSY;
                     else         hr_wr_req <= 1'b1;
                  end
                  CMD_READ_REQ: begin
                     if (hr_busy) state <= S_WAIT_BUSY;
                     else         hr_rd_req <= 1'b1;
                  end
                  default: ;
               endcase
            end
            S_WAIT_BUSY: begin
               if (!hr_busy) begin
                  if (cmd == CMD_WRITE) hr_wr_req <= 1'b1;
                  else                  hr_rd_req <= 1'b1;
                  state <= S_LOAD_RESP;
               end
            end
            S_LOAD_RESP: begin
               resp_reg <= resp_c;
               tx_left  <= 3'd4;
               if (cmd == CMD_COUNT) count <= count + 32'd1;
               state    <= S_TX_BYTE;
            end
            S_TX_BYTE: begin
               if (tx_ready) begin
                  tx_start <= 1'b1;
                  tx_data  <= resp_reg[31:24];
                  state    <= S_TX_WAIT;
               end
            end
            S_TX_WAIT: begin
               // uart_tx drops ready a couple of clocks after the start strobe
               if (tx_ready_q && !tx_ready) begin
                  resp_reg <= {resp_reg[23:0], 8'h00};
                  tx_left  <= tx_left - 3'd1;
                  state    <= (tx_left == 3'd1) ? S_RX : S_TX_BYTE;
               end
            end
            default: state <= S_RX;
         endcase
      end
   end

endmodule

// File: tb/tb_hram_cmd_ctrl.sv
// Self-checking bench for hram_cmd_ctrl: directed table, corner sequences and
// random frames against a frame-level reference model with UART and HyperRAM stubs.
module tb_hram_cmd_ctrl;

   localparam int unsigned TO = 40;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        rx_rcv = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b1;
   logic [31:0] hr_addr;
   logic [31:0] hr_wr_d;
   logic        hr_wr_req;
   logic        hr_rd_req;
   logic        hr_busy = 1'b0;
   logic        hr_rd_rdy = 1'b0;
   logic [31:0] hr_rd_d = 32'd0;
   logic [7:0]  drop_cnt;

   hram_cmd_ctrl #(.CONST_VAL(32'd259), .FRAME_TIMEOUT(TO)) dut (
      .clk(clk), .rstn(rstn), .rx_rcv(rx_rcv), .rx_data(rx_data),
      .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready),
      .hr_addr(hr_addr), .hr_wr_d(hr_wr_d), .hr_wr_req(hr_wr_req), .hr_rd_req(hr_rd_req),
      .hr_busy(hr_busy), .hr_rd_rdy(hr_rd_rdy), .hr_rd_d(hr_rd_d), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_addr = 32'd0, m_wr_d = 32'd0, m_count = 32'd0, m_rd_latch = 32'd0;
   logic [31:0] rd_val = 32'd0;
   int          m_drop = 0;
   logic [7:0]  tx_q[$];
   int          wr_pulses = 0, rd_pulses = 0, uc = 0, rd_delay = 0;

   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] d;
      int          busy;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_resp(input logic [7:0] cmd, input logic [31:0] d);
      case (cmd)
         8'd1, 8'd2: return d;
         8'd3:       return 32'd3;
         8'd4:       return m_rd_latch;
         8'd5:       return 32'd5;
         8'd6:       return m_count;
         8'd7:       return 32'd259;
         default:    return {24'hEEEEEE, cmd};
      endcase
   endfunction

   task automatic drop_one();
      if (m_drop < 255) m_drop++;
   endtask

   // UART tx stub (ready falls 2 clks after start, idle again 6 clks later) and HyperRAM stub
   always @(negedge clk) begin
      if (tx_start) begin
         check("tx_ready_at_start", {31'd0, tx_ready}, 32'd1);
         tx_q.push_back(tx_data);
         uc = 1;
      end else if (uc > 0) begin
         uc++;
         if (uc == 3) tx_ready = 1'b0;
         else if (uc == 9) begin
            tx_ready = 1'b1;
            uc = 0;
         end
      end
      if (hr_wr_req || hr_rd_req) check("req_exclusive", {31'd0, hr_wr_req & hr_rd_req}, 32'd0);
      if (hr_wr_req) wr_pulses++;
      hr_rd_rdy = 1'b0;
      if (rd_delay > 0) begin
         rd_delay--;
         if (rd_delay == 0) begin
            hr_rd_rdy  = 1'b1;
            hr_rd_d    = rd_val;
            m_rd_latch = rd_val;
         end
      end
      if (hr_rd_req) begin
         rd_pulses++;
         rd_delay = 3;
      end
   end

   task automatic send_byte(input logic [7:0] v);
      @(negedge clk);
      rx_rcv  = 1'b1;
      rx_data = v;
      @(negedge clk);
      rx_rcv  = 1'b0;
   endtask

   task automatic do_frame(input logic [7:0] cmd, input logic [31:0] d, input int busy,
                           input bit inject, input int gap, input logic [31:0] exp, input string tag);
      logic [7:0]  b[5];
      int          w0, r0, n;
      bit          inj_done;
      logic [31:0] got;
      b[0] = cmd; b[1] = d[31:24]; b[2] = d[23:16]; b[3] = d[15:8]; b[4] = d[7:0];
      w0 = wr_pulses; r0 = rd_pulses; inj_done = 1'b0;
      tx_q.delete();
      if (busy > 0) begin
         @(negedge clk);
         hr_busy = 1'b1;
      end
      for (int i = 0; i < 5; i++) begin
         send_byte(b[i]);
         if (i == 1) repeat (gap) @(negedge clk);
      end
      if (busy == 0) begin
         @(negedge clk);
         check({tag, " req_latency"}, {30'd0, hr_wr_req, hr_rd_req}, {30'd0, cmd == 8'd3, cmd == 8'd5});
      end else begin
         repeat (busy) @(negedge clk);
         check({tag, " req_held_busy"}, {30'd0, hr_wr_req, hr_rd_req}, 32'd0);
         hr_busy = 1'b0;
         @(negedge clk);
         check({tag, " req_after_busy"}, {30'd0, hr_wr_req, hr_rd_req}, {30'd0, cmd == 8'd3, cmd == 8'd5});
      end
      case (cmd)
         8'd1: m_addr = d;
         8'd2: m_wr_d = d;
         8'd6: m_count = m_count + 32'd1;
         default: ;
      endcase
      n = 0;
      while (tx_q.size() < 4 && n < 400) begin
         @(negedge clk);
         rx_rcv = 1'b0;
         if (inject && !inj_done && tx_q.size() >= 1 && tx_q.size() < 3) begin
            rx_rcv   = 1'b1;
            rx_data  = 8'hA5;
            inj_done = 1'b1;
            drop_one();
         end
         n++;
      end
      @(negedge clk);
      rx_rcv = 1'b0;
      repeat (12) @(negedge clk);
      check({tag, " tx_pulses"}, 32'(tx_q.size()), 32'd4);
      got = 32'd0;
      for (int i = 0; i < tx_q.size() && i < 4; i++) got = {got[23:0], tx_q[i]};
      check({tag, " resp"}, got, exp);
      check({tag, " wr_pulses"}, 32'(wr_pulses - w0), {31'd0, cmd == 8'd3});
      check({tag, " rd_pulses"}, 32'(rd_pulses - r0), {31'd0, cmd == 8'd5});
      check({tag, " hr_addr"}, hr_addr, m_addr);
      check({tag, " hr_wr_d"}, hr_wr_d, m_wr_d);
      check({tag, " drop_cnt"}, {24'd0, drop_cnt}, 32'(m_drop));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  rc;
      logic [31:0] rd;
      int          rb, n;

      tbl[0]  = '{8'h01, 32'h0000002A, 0,  32'h0000002A};
      tbl[1]  = '{8'h02, 32'hDEADBEEF, 0,  32'hDEADBEEF};
      tbl[2]  = '{8'h03, 32'h00000000, 10, 32'h00000003};
      tbl[3]  = '{8'h05, 32'h00000000, 0,  32'h00000005};
      tbl[4]  = '{8'h04, 32'h00000000, 0,  32'h12345678};
      tbl[5]  = '{8'h06, 32'h00000000, 0,  32'h00000000};
      tbl[6]  = '{8'h06, 32'hFFFFFFFF, 0,  32'h00000001};
      tbl[7]  = '{8'h06, 32'h00000000, 0,  32'h00000002};
      tbl[8]  = '{8'h07, 32'h00000000, 0,  32'h00000103};
      tbl[9]  = '{8'h09, 32'h11223344, 0,  32'hEEEEEE09};
      tbl[10] = '{8'h05, 32'h00000000, 5,  32'h00000005};

      repeat (3) @(negedge clk);
      check("reset tx", {23'd0, tx_start, tx_data}, 32'd0);
      check("reset hr_addr", hr_addr, 32'd0);
      check("reset hr_wr_d", hr_wr_d, 32'd0);
      check("reset req_drop", {22'd0, hr_wr_req, hr_rd_req, drop_cnt}, 32'd0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      rd_val = 32'h12345678;
      for (int i = 0; i < 11; i++)
         do_frame(tbl[i].cmd, tbl[i].d, tbl[i].busy, 1'b0, 0, tbl[i].exp, $sformatf("vec%0d", i));

      // Partial frame discarded after the idle timeout, then a clean frame
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
      repeat (TO + 1) @(negedge clk);
      drop_one();
      check("timeout drop_cnt", {24'd0, drop_cnt}, 32'(m_drop));
      do_frame(8'h01, 32'h5, 0, 1'b0, 0, 32'h5, "after_timeout");
      do_frame(8'h02, 32'hCAFE0001, 0, 1'b0, TO - 2, 32'hCAFE0001, "gap_below_timeout");

      // Bytes arriving during the response are dropped
      do_frame(8'h07, 32'h0, 0, 1'b1, 0, 32'h103, "drop_during_tx");

      // Reset in the middle of a response
      send_byte(8'h07); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      n = 0;
      while (tx_q.size() < 1 && n < 200) begin @(negedge clk); n++; end
      n = 0;
      while (!tx_start && n < 200) begin @(negedge clk); n++; end
      check("tx_start before reset", {31'd0, tx_start}, 32'd1);
      rstn = 1'b0;
      #1;
      check("midrst tx", {23'd0, tx_start, tx_data}, 32'd0);
      check("midrst hr_addr", hr_addr, 32'd0);
      check("midrst hr_wr_d", hr_wr_d, 32'd0);
      check("midrst drop_cnt", {24'd0, drop_cnt}, 32'd0);
      m_addr = 32'd0; m_wr_d = 32'd0; m_count = 32'd0; m_rd_latch = 32'd0; m_drop = 0;
      @(negedge clk);
      rstn = 1'b1;
      repeat (20) @(negedge clk);
      do_frame(8'h06, 32'h0, 0, 1'b0, 0, 32'h0, "count_after_reset");
      do_frame(8'h04, 32'h0, 0, 1'b0, 0, 32'h0, "rd_latch_after_reset");

      // Random frames against the model
      for (int i = 0; i < 40; i++) begin
         rc     = 8'($urandom_range(0, 9));
         rd     = $urandom;
         rd_val = $urandom;
         rb     = ((rc == 8'd3 || rc == 8'd5) && ($urandom_range(0, 1) == 1)) ? int'($urandom_range(3, 8)) : 0;
         do_frame(rc, rd, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TO - 2)) : 0,
                  model_resp(rc, rd), $sformatf("rnd%0d", i));
      end

      // drop_cnt saturates at 255
      for (int i = 0; i < 256; i++) begin
         send_byte(8'h07);
         repeat (TO + 1) @(negedge clk);
         drop_one();
      end
      check("drop_cnt saturate", {24'd0, drop_cnt}, 32'd255);
      do_frame(8'h07, 32'h0, 0, 1'b1, 0, 32'h103, "after_saturate");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
